// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaler and R-bit period counter
// (edge or centre aligned), shadowed duty registers applied at period boundaries.
module pwm_multi #(
  parameter int CH         = 4,
  parameter int R          = 8,
  parameter int TIMER_BITS = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [TIMER_BITS-1:0] prescale,
  input  logic                  center_mode,
  input  logic                  load,
  input  logic [CH*(R+1)-1:0]   duty_in,
  output logic [CH-1:0]         pwm_out,
  output logic                  period_start
);

  localparam logic [R-1:0] MAX = '1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [TIMER_BITS-1:0] pcnt;
  logic [R-1:0]          q;
  logic [R-1:0]          q_next;
  dir_t                  dir;
  dir_t                  dir_next;
  logic                  mode_act;
  logic [CH*(R+1)-1:0]   shadow;
  logic [CH*(R+1)-1:0]   active;
  logic [CH-1:0]         cmp;
  logic                  tick;
  logic                  boundary;

  // ">=" rather than "==" so lowering prescale below pcnt never stalls a wrap.
  assign tick     = enable && (pcnt >= prescale);
  assign boundary = tick && (q != '0) && (q_next == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (!enable || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always_comb begin
    q_next   = q;
    dir_next = dir;
    if (!mode_act) begin
      q_next = q + 1'b1;
    end else if (dir == DIR_UP) begin
      if (q == MAX) begin
        q_next   = MAX - 1'b1;
        dir_next = DIR_DOWN;
      end else begin
        q_next = q + 1'b1;
      end
    end else begin
      if (q == '0) begin
        q_next   = R'(1);
        dir_next = DIR_UP;
      end else begin
        q_next = q - 1'b1;
      end
    end
  end

  // A boundary always restarts from Q=0 counting up, so a mode switch is clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q   <= '0;
      dir <= DIR_UP;
    end else if (!enable) begin
      q   <= '0;
      dir <= DIR_UP;
    end else if (boundary) begin
      q   <= '0;
      dir <= DIR_UP;
    end else if (tick) begin
      q   <= q_next;
      dir <= dir_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= duty_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active   <= '0;
      mode_act <= 1'b0;
    end else if (!enable || boundary) begin
      active   <= shadow;
      mode_act <= center_mode;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [R:0] duty_act;
    assign duty_act = active[i*(R+1) +: R+1];
    assign cmp[i]   = {1'b0, q} < duty_act;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else if (!enable) begin
      pwm_out      <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (tick) begin
        pwm_out <= cmp;
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: per-period window records (length, high clocks per
// channel) are queued by the driver and checked at each period_start.
module tb_pwm_multi;

  localparam int CH    = 4;
  localparam int R     = 8;
  localparam int TBITS = 15;
  localparam int DW    = CH * (R + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [TBITS-1:0] prescale;
  logic             center_mode;
  logic             load;
  logic [DW-1:0]    duty_in;
  logic [CH-1:0]    pwm_out;
  logic             period_start;

  logic             check_on;
  logic [59:0]      exp_q[$];
  logic [59:0]      mon_e;
  int               n_cmp  = 0;
  int               n_fail = 0;
  int               win_len;
  int               hcnt[CH];

  pwm_multi #(.CH(CH), .R(R), .TIMER_BITS(TBITS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .prescale     (prescale),
    .center_mode  (center_mode),
    .load         (load),
    .duty_in      (duty_in),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_win(input int len, input int h0, input int h1, input int h2, input int h3);
    exp_q.push_back({12'(len), 12'(h0), 12'(h1), 12'(h2), 12'(h3)});
  endtask

  task automatic load_duty(input int d0, input int d1, input int d2, input int d3);
    duty_in = {9'(d3), 9'(d2), 9'(d1), 9'(d0)};
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Returns #1 after the clock edge that follows a period_start pulse.
  task automatic sync_ps();
    int n;
    n = 0;
    @(negedge clk);
    while (!period_start && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("sync_period_start_seen", int'(period_start), 1);
    @(posedge clk); #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    win_len = 0;
    for (int i = 0; i < CH; i++) hcnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || !enable) begin
        win_len = 0;
        for (int i = 0; i < CH; i++) hcnt[i] = 0;
      end else begin
        win_len++;
        for (int i = 0; i < CH; i++) hcnt[i] += int'(pwm_out[i]);
        if (period_start) begin
          if (check_on) begin
            if (exp_q.size() == 0) begin
              check("window_unexpected", 1, 0);
            end else begin
              mon_e = exp_q.pop_front();
              check("win_len", win_len, int'(mon_e[59:48]));
              for (int i = 0; i < CH; i++)
                check($sformatf("win_ch%0d_high", i), hcnt[i], int'(mon_e[47-12*i -: 12]));
            end
          end
          win_len = 0;
          for (int i = 0; i < CH; i++) hcnt[i] = 0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    int n;
    logic found;
    reset_n = 1'b0; enable = 1'b0; center_mode = 1'b0; load = 1'b0;
    prescale = '0; duty_in = '0; check_on = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_period_start", int'(period_start), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // edge mode, basic duties and extremes
    load_duty(64, 0, 255, 256);
    @(posedge clk); #1;
    check("disabled_pwm_out", int'(pwm_out), 0);
    enable = 1'b1;
    sync_ps();
    push_win(256, 64, 0, 255, 256);
    check_on = 1'b1;

    // shadow load mid-period (Q=100)
    repeat (99) @(posedge clk); #1;
    load_duty(200, 0, 255, 256);
    push_win(256, 200, 0, 255, 256);
    sync_ps();

    // load exactly on the boundary posedge: delayed one more period
    repeat (254) @(posedge clk); #1;
    load_duty(100, 0, 255, 256);
    push_win(256, 200, 0, 255, 256);
    push_win(256, 100, 0, 255, 256);
    sync_ps();
    sync_ps();

    // duty 0/1/128 and saturating 300
    repeat (50) @(posedge clk); #1;
    load_duty(0, 1, 128, 300);
    push_win(256, 0, 1, 128, 256);
    sync_ps();

    // centre mode requested mid-period: current period stays edge
    repeat (50) @(posedge clk); #1;
    center_mode = 1'b1;
    load_duty(64, 1, 255, 256);
    push_win(510, 127, 1, 509, 510);
    sync_ps();

    // back to edge mid centre period
    repeat (100) @(posedge clk); #1;
    center_mode = 1'b0;
    push_win(256, 64, 1, 255, 256);
    sync_ps();
    sync_ps();

    // prescale = 3
    check_on = 1'b0;
    prescale = 15'd3;
    sync_ps();
    push_win(1024, 256, 4, 1020, 1024);
    check_on = 1'b1;
    sync_ps();
    check_on = 1'b0;

    // pcnt is 1 here; raise prescale to 1000, let pcnt reach 500, drop to 2
    prescale = 15'd1000;
    repeat (499) @(posedge clk); #1;
    prescale = 15'd2;
    @(negedge clk);
    check("prescale_drop_before_tick", int'(pwm_out[2]), 0);
    @(negedge clk);
    check("prescale_drop_tick_next_clk", int'(pwm_out[2]), 1);

    // asynchronous reset mid-period with outputs high
    @(posedge clk); #1;
    prescale = '0;
    sync_ps();
    sync_ps();
    check("pre_reset_pwm_high", int'(pwm_out), 15);
    reset_n = 1'b0;
    #1;
    check("async_reset_pwm_out", int'(pwm_out), 0);
    check("async_reset_period_start", int'(period_start), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // enable low mid-period, then re-enable
    load_duty(64, 1, 255, 256);
    sync_ps();
    check("pre_disable_pwm_high", int'(pwm_out), 15);
    enable = 1'b0;
    @(posedge clk); #1;
    check("disable_pwm_out", int'(pwm_out), 0);
    check("disable_period_start", int'(period_start), 0);
    repeat (5) @(posedge clk); #1;
    enable = 1'b1;
    n = 0;
    found = 1'b0;
    while (!found && n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      found = period_start;
    end
    check("reenable_ticks_to_period_start", n, 256);
    @(posedge clk); #1;
    push_win(256, 64, 1, 255, 256);
    check_on = 1'b1;
    sync_ps();
    check_on = 1'b0;

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
